// File: rtl/hms_bcd_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : hms_bcd_counter_if
// Description : Control, time-set handshake and display bus of the HMS counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface hms_bcd_counter_if;
    logic       tick_in;
    logic       run;
    logic       load_req;
    logic [7:0] load_h;
    logic [7:0] load_m;
    logic [7:0] load_s;
    logic       load_ack;
    logic       load_err;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       sec_pulse;
    logic       rollover;

    modport master (
        output tick_in, run, load_req, load_h, load_m, load_s,
        input  load_ack, load_err, hour, min, sec, sec_pulse, rollover
    );

    modport slave (
        input  tick_in, run, load_req, load_h, load_m, load_s,
        output load_ack, load_err, hour, min, sec, sec_pulse, rollover
    );
endinterface
`default_nettype wire

// File: rtl/hms_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : hms_bcd_counter
// Description : BCD hh:mm:ss time-of-day counter with synchronised 1 Hz tick
//               input and validated time-set handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module hms_bcd_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  wire            clk,
    input  wire            reset_n,
    hms_bcd_counter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHECK    = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic [7:0]             r_hour, r_min, r_sec;
    logic [7:0]             r_ld_h, r_ld_m, r_ld_s;
    logic                   r_ack, r_err, r_sec_pulse, r_rollover;

    logic                   w_tick_evt;
    logic                   w_load_ok;
    logic                   w_wrap;
    logic [7:0]             w_hour, w_min, w_sec;

    assign w_tick_evt = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_wrap     = (r_hour == 8'h23) && (r_min == 8'h59) && (r_sec == 8'h59);

    // Hour tens/units need a separate units check: 8'h1A is numerically below 8'h23.
    assign w_load_ok = (r_ld_s[7:4] <= 4'd5) && (r_ld_s[3:0] <= 4'd9) &&
                       (r_ld_m[7:4] <= 4'd5) && (r_ld_m[3:0] <= 4'd9) &&
                       (r_ld_h[3:0] <= 4'd9) && (r_ld_h <= 8'h23);

    always_comb begin
        w_hour = r_hour;
        w_min  = r_min;
        w_sec  = r_sec;
        if (r_sec[3:0] != 4'd9) begin
            w_sec[3:0] = r_sec[3:0] + 4'd1;
        end else begin
            w_sec[3:0] = 4'd0;
            if (r_sec[7:4] != 4'd5) begin
                w_sec[7:4] = r_sec[7:4] + 4'd1;
            end else begin
                w_sec[7:4] = 4'd0;
                if (r_min[3:0] != 4'd9) begin
                    w_min[3:0] = r_min[3:0] + 4'd1;
                end else begin
                    w_min[3:0] = 4'd0;
                    if (r_min[7:4] != 4'd5) begin
                        w_min[7:4] = r_min[7:4] + 4'd1;
                    end else begin
                        w_min[7:4] = 4'd0;
                        if (r_hour == 8'h23) begin
                            w_hour = 8'h00;
                        end else if (r_hour[3:0] == 4'd9) begin
                            w_hour = {r_hour[7:4] + 4'd1, 4'd0};
                        end else begin
                            w_hour[3:0] = r_hour[3:0] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_hour      <= 8'h00;
            r_min       <= 8'h00;
            r_sec       <= 8'h00;
            r_ld_h      <= 8'h00;
            r_ld_m      <= 8'h00;
            r_ld_s      <= 8'h00;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_rollover  <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.tick_in};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
            r_ack       <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_rollover  <= 1'b0;

            // A valid load in CHECK swallows a coincident tick entirely.
            if (w_tick_evt && bus.run && !((r_state == S_CHECK) && w_load_ok)) begin
                r_hour      <= w_hour;
                r_min       <= w_min;
                r_sec       <= w_sec;
                r_sec_pulse <= 1'b1;
                r_rollover  <= w_wrap;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.load_req) begin
                        r_ld_h  <= bus.load_h;
                        r_ld_m  <= bus.load_m;
                        r_ld_s  <= bus.load_s;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_ack <= 1'b1;
                    if (w_load_ok) begin
                        r_hour <= r_ld_h;
                        r_min  <= r_ld_m;
                        r_sec  <= r_ld_s;
                        r_err  <= 1'b0;
                    end else begin
                        r_err  <= 1'b1;
                    end
                    r_state <= S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!bus.load_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hour      = r_hour;
    assign bus.min       = r_min;
    assign bus.sec       = r_sec;
    assign bus.load_ack  = r_ack;
    assign bus.load_err  = r_err;
    assign bus.sec_pulse = r_sec_pulse;
    assign bus.rollover  = r_rollover;
endmodule
`default_nettype wire
